rr_arbiter_16: RTL and testbench

//  Round-robin arbiter for 16 requesters. Produces the registered 4-bit index
//  of the winning requester plus a valid strobe. It sits directly upstream of

---
 rtl/rr_arbiter_16_pkg.sv | 11 +
 rtl/rr_arbiter_16_if.sv | 25 ++
 rtl/rr_arbiter_16_pick16.sv | 29 ++
 rtl/rr_arbiter_16.sv | 77 +++++++
 tb/tb_rr_arbiter_16.sv | 129 ++++++++++++
 5 files changed

// File: rtl/rr_arbiter_16_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter.
package rr_arb_pkg;

   localparam int NUM_REQ = 16;
   localparam int IDX_W   = 4;

   typedef enum logic {IDLE, GRANT} rr_state_t;

   typedef logic [IDX_W-1:0] rr_idx_t;

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Requester-side bus of the arbiter, plus FSM debug visibility.
// Handshake: req[i] is a level request that must stay high while requester i
// wants the grant; gnt_valid/gnt_idx name the owner, done ends ownership.
interface rr_arbiter_16_if;
   import rr_arb_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic               done;
   logic               gnt_valid;
   rr_idx_t            gnt_idx;
   logic               timeout;
   rr_state_t          dbg_state;
   rr_idx_t            dbg_ptr;

   modport master (
      output req, done,
      input  gnt_valid, gnt_idx, timeout, dbg_state, dbg_ptr
   );

   modport slave (
      input  req, done,
      output gnt_valid, gnt_idx, timeout, dbg_state, dbg_ptr
   );

endinterface

// File: rtl/rr_arbiter_16_pick16.sv
// Combinational round-robin pick: first set request at or after ptr, mod 16.
module rr_pick16
   import rr_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  rr_idx_t            i_ptr,
   output rr_idx_t            o_idx,
   output logic               o_any
);

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   rr_idx_t              w_first;

   // Rotate so that bit ptr lands at position 0.
   assign w_dbl = {i_req, i_req};
   assign w_rot = w_dbl[i_ptr +: NUM_REQ];

   always_comb begin
      w_first = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) w_first = rr_idx_t'(i);
      end
   end

   assign o_idx = w_first + i_ptr;
   assign o_any = |i_req;

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter, 16 requesters, registered grant index with hold timeout.
module rr_arbiter_16
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_arbiter_16_if.slave bus
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   localparam bit         TMO_EN    = (MAX_HOLD != 0);

   rr_state_t  r_state;
   rr_idx_t    r_ptr;
   rr_idx_t    r_gnt_idx;
   logic       r_gnt_valid;
   logic       r_timeout;
   logic [7:0] r_hold_cnt;

   rr_idx_t    w_pick_idx;
   logic       w_pick_any;

   rr_pick16 u_pick (
      .i_req (bus.req),
      .i_ptr (r_ptr),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_gnt_idx   <= '0;
         r_gnt_valid <= 1'b0;
         r_timeout   <= 1'b0;
         r_hold_cnt  <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_any) begin
                  r_gnt_idx   <= w_pick_idx;
                  r_gnt_valid <= 1'b1;
                  r_hold_cnt  <= '0;
                  r_state     <= GRANT;
               end
            end
            GRANT: begin
               // done and withdrawal outrank the timeout, so no pulse then.
               if (bus.done || !bus.req[r_gnt_idx]) begin
                  r_gnt_valid <= 1'b0;
                  r_ptr       <= r_gnt_idx + 1'b1;
                  r_state     <= IDLE;
               end else if (TMO_EN && (r_hold_cnt == HOLD_LAST)) begin
                  r_gnt_valid <= 1'b0;
                  r_ptr       <= r_gnt_idx + 1'b1;
                  r_timeout   <= 1'b1;
                  r_state     <= IDLE;
               end else if (r_hold_cnt != 8'hFF) begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt_valid = r_gnt_valid;
   assign bus.gnt_idx   = r_gnt_idx;
   assign bus.timeout   = r_timeout;
   assign bus.dbg_state = r_state;
   assign bus.dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: per-cycle expected outputs checked by a monitor.
module tb_rr_arbiter_16;
   import rr_arb_pkg::*;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   failures;
   string cur_test;

   // {target cycle[37:6], gnt_valid, timeout, gnt_idx[3:0]}
   logic [37:0] exp_q[$];
   logic [37:0] mon_item;

   rr_arbiter_16_if bus ();

   rr_arbiter_16 #(.MAX_HOLD(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic step(input logic rst, input logic [15:0] rq, input logic dn,
                       input logic ev, input logic et, input logic [3:0] ei);
      @(negedge clk);
      #1;
      rst_n    = rst;
      bus.req  = rq;
      bus.done = dn;
      exp_q.push_back({32'(cyc + 1), ev, et, ei});
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0 && int'(exp_q[0][37:6]) <= cyc) begin
         mon_item = exp_q.pop_front();
         checks++;
         if (int'(mon_item[37:6]) != cyc ||
             {bus.gnt_valid, bus.timeout, bus.gnt_idx} != mon_item[5:0]) begin
            failures++;
            $display("FAIL %s cyc=%0d got v/t/idx=%b/%b/%0d expected v/t/idx=%b/%b/%0d",
                     cur_test, cyc, bus.gnt_valid, bus.timeout, bus.gnt_idx,
                     mon_item[5], mon_item[4], mon_item[3:0]);
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.req  = '0;
      bus.done = 1'b0;

      cur_test = "reset";
      step(0, 16'h0000, 0, 0, 0, 4'd0);
      step(0, 16'h0000, 0, 0, 0, 4'd0);

      cur_test = "idle_no_req";
      for (int i = 0; i < 5; i++) step(1, 16'h0000, 0, 0, 0, 4'd0);

      cur_test = "single_req_done";
      step(1, 16'h0020, 0, 1, 0, 4'd5);
      step(1, 16'h0020, 1, 0, 0, 4'd5);
      step(1, 16'h0021, 0, 1, 0, 4'd0);
      step(1, 16'h0021, 1, 0, 0, 4'd0);
      step(1, 16'h0000, 0, 0, 0, 4'd0);

      cur_test = "all_req_rotation";
      step(0, 16'h0000, 0, 0, 0, 4'd0);
      for (int i = 0; i < 17; i++) begin
         step(1, 16'hFFFF, 1, 1, 0, 4'(i));
         step(1, 16'hFFFF, 1, 0, 0, 4'(i));
      end
      step(1, 16'h0000, 0, 0, 0, 4'd0);

      cur_test = "hold_timeout";
      step(1, 16'h0100, 0, 1, 0, 4'd8);
      for (int i = 0; i < 14; i++) step(1, 16'h0100, 0, 1, 0, 4'd8);
      step(1, 16'h0100, 0, 0, 1, 4'd8);
      step(1, 16'h0100, 0, 1, 0, 4'd8);
      step(1, 16'h0000, 0, 0, 0, 4'd8);
      step(1, 16'h0000, 0, 0, 0, 4'd8);

      cur_test = "withdrawal";
      step(1, 16'h0008, 0, 1, 0, 4'd3);
      step(1, 16'h0208, 0, 1, 0, 4'd3);
      step(1, 16'h0200, 0, 0, 0, 4'd3);
      step(1, 16'h0200, 0, 1, 0, 4'd9);

      cur_test = "done_vs_timeout";
      for (int i = 0; i < 14; i++) step(1, 16'h0200, 0, 1, 0, 4'd9);
      step(1, 16'h0200, 1, 0, 0, 4'd9);

      cur_test = "done_and_withdraw";
      step(1, 16'h0200, 0, 1, 0, 4'd9);
      step(1, 16'h0000, 1, 0, 0, 4'd9);
      step(1, 16'h0000, 0, 0, 0, 4'd9);

      cur_test = "reset_mid_grant";
      step(1, 16'h1000, 0, 1, 0, 4'd12);
      step(0, 16'hFFFF, 0, 0, 0, 4'd0);
      step(1, 16'hFFFF, 0, 1, 0, 4'd0);
      step(1, 16'hFFFF, 1, 0, 0, 4'd0);
      step(1, 16'hFFFF, 0, 1, 0, 4'd1);
      step(1, 16'h0000, 0, 0, 0, 4'd1);

      cur_test = "drain";
      repeat (4) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d expected pending=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
